serial_sub_nbit: RTL and testbench
==================================

Name: serial_sub_nbit

Overview:
Bit-serial N-bit subtractor computing DIFF = A - B - B_IN, LSB first, one bit per clock. Each bit passes through a registered full-subtractor slice with a stored borrow. It is the subtract-direction companion to the team's full-adder datapath cells. It trades the area of a ripple array for N cycles of latency, and uses a start/busy/done handshake so a controller or testbench can sequence operations.

Parameters:
N, 4, operand and result width in bits (N >= 2)
CW, $clog2(N)+1, bit-counter width (derived, not overridden)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
A  input  N  minuend, captured on the accepting edge
B  input  N  subtrahend, captured on the accepting edge
B_IN  input  1  borrow-in, captured on the accepting edge
busy  output  1  high while an operation is in progress (LOAD-accepted through last bit)
done  output  1  one-cycle pulse: result valid
DIFF  output  N  difference; holds until the next accepted start
B_OUT  output  1  final borrow-out; holds with DIFF

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset. While reset is high at an edge: state=IDLE, busy=0, done=0, DIFF=0, B_OUT=0, counter=0, shift registers=0.
- FSM states:
  - IDLE: busy=0. start=1 at an edge loads a_sh=A, b_sh=B, borrow=B_IN, cnt=0, and moves to RUN.
  - RUN: busy=1. Each edge processes bit0 of a_sh/b_sh:
    - d = a0^b0^borrow
    - borrow_next = (~a0&b0) | (~(a0^b0)&borrow)
    - a_sh, b_sh shift right by 1
    - the result shift register shifts right with d inserted at the MSB
    - cnt++
  - RUN exit: on the edge where cnt==N-1 (last bit), DIFF <= final result register, B_OUT <= borrow_next, state -> DONE.
  - DONE: done=1, busy=0 for exactly one cycle, then unconditionally -> IDLE.
- start is ignored in RUN and DONE. No queuing, operands not re-captured. Captured operands are immune to later A/B/B_IN changes.
- Latency: with start accepted at edge t, done is high in the cycle after edge t+N. Back-to-back throughput is one operation per N+2 cycles.
- DIFF/B_OUT change only on the RUN->DONE transition and on reset. Intermediate bits are never visible on DIFF.
- Arithmetic: DIFF = (A - B - B_IN) mod 2^N. B_OUT=1 iff A < B + B_IN as unsigned integers.
- Boundary cases:
  - A=0, B=2^N-1, B_IN=1 gives DIFF=0, B_OUT=1.
  - A=B, B_IN=0 gives DIFF=0, B_OUT=0.
- Reset mid-RUN aborts the operation: outputs clear to 0 and no done pulse occurs.
- start and reset high on the same edge: reset wins.

Decomposition:
- Shared package/include holds:
  - FSM state encodings: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - default width N
- One natural sub-module: fullsub, purely combinational, ports (D, B_OUT, A, B, B_IN) in the same positional order as fulladd. Instantiated once inside serial_sub_nbit. The borrow register stays in the parent.

Test Plan:
1. N=4, A=5, B=3, B_IN=0, start one cycle -> busy high 4 cycles, done pulse on cycle 5 after accept, DIFF=4'd2, B_OUT=0.
2. A=3, B=5, B_IN=0 -> DIFF=4'b1110, B_OUT=1. Then A=0, B=0, B_IN=1 -> DIFF=4'b1111, B_OUT=1.
3. A=9, B=2, start; pulse start again with A=1, B=1 two cycles later while busy -> only one done pulse, DIFF=4'd7. Second request ignored.
4. Change A/B every cycle during RUN after a start with A=12, B=4 -> DIFF=4'd8, B_OUT=0 (captured values used).
5. Assert reset in the second RUN cycle of A=15, B=1 -> next cycle busy=0, done=0, DIFF=0, B_OUT=0, no later done. A fresh start then completes normally.
6. Exhaustive: all 512 (A, B, B_IN) combinations with N=4, back-to-back starts in IDLE -> each DIFF/B_OUT matches the {B_OUT, DIFF} = {1'b0, A} - B - B_IN reference model, and done spacing is exactly N+2 cycles.

Source files
------------

// File: rtl/serial_sub_nbit_pkg.sv
// serial_sub_nbit_pkg: FSM state encoding and default operand width for the bit-serial subtractor
package serial_sub_nbit_pkg;
    localparam int N_DEFAULT = 4;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/serial_sub_nbit_if.sv
// serial_sub_nbit_if: start/busy/done handshake plus operand and result buses
interface serial_sub_nbit_if import serial_sub_nbit_pkg::*; #(parameter int N = N_DEFAULT);
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         B_IN;
    logic         busy;
    logic         done;
    logic [N-1:0] DIFF;
    logic         B_OUT;
    modport master (output start, A, B, B_IN, input busy, done, DIFF, B_OUT);
    modport slave  (input start, A, B, B_IN, output busy, done, DIFF, B_OUT);
endinterface

// File: rtl/serial_sub_nbit_fullsub.sv
// fullsub: combinational one-bit full subtractor, same positional port order as fulladd
module fullsub (
    output logic D,
    output logic B_OUT,
    input  logic A,
    input  logic B,
    input  logic B_IN
);
    assign D     = A ^ B ^ B_IN;
    assign B_OUT = (~A & B) | (~(A ^ B) & B_IN);
endmodule

// File: rtl/serial_sub_nbit.sv
// serial_sub_nbit: LSB-first bit-serial N-bit subtractor, DIFF = A - B - B_IN over N clocks
module serial_sub_nbit import serial_sub_nbit_pkg::*; #(
    parameter int N = N_DEFAULT
) (
    input logic               clk,
    input logic               reset,
    serial_sub_nbit_if.slave  bus
);
    localparam int CW = $clog2(N) + 1;
    state_t        state, state_nx;
    logic [N-1:0]  a_sh, b_sh, res, res_nx;
    logic [CW-1:0] cnt;
    logic          borrow, borrow_nx, d, last;
    fullsub u_fs (
        .D     (d),
        .B_OUT (borrow_nx),
        .A     (a_sh[0]),
        .B     (b_sh[0]),
        .B_IN  (borrow)
    );
    assign last   = cnt == CW'(N - 1);
    assign res_nx = {d, res[N-1:1]};
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end
    always_comb begin
        state_nx = ST_IDLE;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        state_nx = (state == ST_IDLE) ? (bus.start ? ST_RUN : ST_IDLE) :
                   (state == ST_RUN)  ? (last ? ST_DONE : ST_RUN) : ST_IDLE;
        bus.busy = state == ST_RUN;
        bus.done = state == ST_DONE;
    end
    // Result is published only on the last bit so partial sums never reach DIFF
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res       <= '0;
            borrow    <= 1'b0;
            cnt       <= '0;
            bus.DIFF  <= '0;
            bus.B_OUT <= 1'b0;
        end else if (state == ST_IDLE && bus.start) begin
            a_sh   <= bus.A;
            b_sh   <= bus.B;
            borrow <= bus.B_IN;
            cnt    <= '0;
        end else if (state == ST_RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res    <= res_nx;
            borrow <= borrow_nx;
            cnt    <= cnt + CW'(1);
            if (last) begin
                bus.DIFF  <= res_nx;
                bus.B_OUT <= borrow_nx;
            end
        end
    end
endmodule

// File: tb/tb_serial_sub_nbit.sv
// tb_serial_sub_nbit: directed and exhaustive checks of serial_sub_nbit against a cycle-timeline model
module tb_serial_sub_nbit;
    localparam int N = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_checks = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int cyc = 0;
    int last_done = -1;
    bit spacing_on = 1'b0;
    serial_sub_nbit_if #(.N(N)) bus ();
    serial_sub_nbit #(.N(N)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    // Model: operation timeline in cycles plus plain integer subtraction
    int         m_left = 0;
    logic       m_done = 1'b0;
    logic [N:0] m_val = '0;
    logic [N-1:0] m_diff = '0;
    logic       m_bout = 1'b0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_diff <= '0;
            m_bout <= 1'b0;
        end else if (m_left == 0 && !m_done && bus.start) begin
            m_left <= N;
            m_val  <= {1'b0, bus.A} - bus.B - bus.B_IN;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                {m_bout, m_diff} <= m_val;
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        chk("busy", 32'(bus.busy), 32'(m_left != 0));
        chk("done", 32'(bus.done), 32'(m_done));
        chk("diff", 32'(bus.DIFF), 32'(m_diff));
        chk("b_out", 32'(bus.B_OUT), 32'(m_bout));
        if (bus.done === 1'b1) begin
            done_cnt++;
            if (spacing_on && last_done >= 0) chk("spacing", 32'(cyc - last_done), N + 2);
            last_done = cyc;
        end
    end

    task automatic op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bi,
                      input logic [N-1:0] ed, input logic eb, input bit lat_chk);
        int n;
        @(negedge clk);
        bus.A = a; bus.B = b; bus.B_IN = bi; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (lat_chk) chk("latency", 32'(n), N);
        else if (n >= 20) chk("timeout", 32'(n), N);
        chk("lit_diff", 32'(bus.DIFF), 32'(ed));
        chk("lit_bout", 32'(bus.B_OUT), 32'(eb));
    endtask

    initial begin
        int busy_n, dc;
        bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.B_IN = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_diff", 32'(bus.DIFF), 0);
        reset = 1'b0;
        // 1: basic, with busy-length count
        @(negedge clk);
        bus.A = 4'd5; bus.B = 4'd3; bus.B_IN = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        busy_n = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.busy) busy_n++;
            @(negedge clk);
        end
        chk("busy_len", 32'(busy_n), N);
        chk("t1_diff", 32'(bus.DIFF), 2);
        chk("t1_bout", 32'(bus.B_OUT), 0);
        op(4'd5, 4'd3, 1'b0, 4'd2, 1'b0, 1'b1);
        // 2: negative results
        op(4'd3, 4'd5, 1'b0, 4'b1110, 1'b1, 1'b1);
        op(4'd0, 4'd0, 1'b1, 4'b1111, 1'b1, 1'b1);
        // boundary cases
        op(4'd0, 4'd15, 1'b1, 4'd0, 1'b1, 1'b1);
        op(4'd6, 4'd6, 1'b0, 4'd0, 1'b0, 1'b1);
        // 3: start while busy is ignored
        @(negedge clk);
        dc = done_cnt;
        bus.A = 4'd9; bus.B = 4'd2; bus.B_IN = 1'b0; bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk); bus.A = 4'd1; bus.B = 4'd1; bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        repeat (10) @(negedge clk);
        chk("t3_dones", 32'(done_cnt - dc), 1);
        chk("t3_diff", 32'(bus.DIFF), 7);
        // 4: operand changes during RUN
        @(negedge clk);
        bus.A = 4'd12; bus.B = 4'd4; bus.B_IN = 1'b0; bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        for (int i = 0; i < N + 2; i++) begin
            bus.A = 4'($urandom); bus.B = 4'($urandom); bus.B_IN = 1'($urandom);
            @(negedge clk);
        end
        chk("t4_diff", 32'(bus.DIFF), 8);
        chk("t4_bout", 32'(bus.B_OUT), 0);
        // 5: reset in second RUN cycle aborts
        bus.A = 4'd15; bus.B = 4'd1; bus.B_IN = 1'b0; bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("t5_busy", 32'(bus.busy), 0);
        chk("t5_done", 32'(bus.done), 0);
        chk("t5_diff", 32'(bus.DIFF), 0);
        chk("t5_bout", 32'(bus.B_OUT), 0);
        dc = done_cnt;
        repeat (N + 4) @(negedge clk);
        chk("t5_nodone", 32'(done_cnt - dc), 0);
        // start and reset on the same edge: reset wins
        bus.start = 1'b1; reset = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; reset = 1'b0;
        chk("rst_wins", 32'(bus.busy), 0);
        op(4'd15, 4'd1, 1'b0, 4'd14, 1'b0, 1'b1);
        // 6: exhaustive, back-to-back
        spacing_on = 1'b1;
        last_done = -1;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int bi = 0; bi < 2; bi++)
                    op(4'(a), 4'(b), 1'(bi), 4'(a - b - bi), 1'(a < b + bi), 1'b0);
        spacing_on = 1'b0;
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
